// File: rtl/m_div_unit_if.sv
`default_nettype none
// ============================================================================
//  m_div_unit_if
//  Request/response and divider-core signal bundle for the RV32M divide unit.
//  Revision: 1.0
// ============================================================================
interface m_div_unit_if;
  logic        req_valid;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] result;
  logic        core_start;
  logic [31:0] core_numerator;
  logic [31:0] core_denominator;
  logic [31:0] core_quotient;
  logic [31:0] core_remainder;
  logic        core_resp;

  modport slave (
    input  req_valid, op, rs1, rs2, flush,
    input  core_quotient, core_remainder, core_resp,
    output stall, resp_valid, result,
    output core_start, core_numerator, core_denominator
  );

  modport master (
    output req_valid, op, rs1, rs2, flush,
    output core_quotient, core_remainder, core_resp,
    input  stall, resp_valid, result,
    input  core_start, core_numerator, core_denominator
  );
endinterface
`default_nettype wire

// File: rtl/m_div_unit.sv
`default_nettype none
// ============================================================================
//  m_div_unit
//  RV32M DIV/DIVU/REM/REMU front-end: sign handling, special cases, one-entry
//  result cache, and sequencing of an external iterative unsigned divider.
//  Revision: 1.0
// ============================================================================
module m_div_unit (
  input  wire logic   clk,
  input  wire logic   rst,
  m_div_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0]  op_r;
  logic [31:0] rs1_r;
  logic [31:0] rs2_r;
  logic        sq_r;
  logic        sr_r;
  logic [31:0] cq_r;
  logic [31:0] cr_r;
  logic [31:0] result_r;
  logic [31:0] core_num_r;
  logic [31:0] core_den_r;
  logic        cache_valid;
  logic [64:0] cache_tag;
  logic [31:0] cache_q;
  logic [31:0] cache_r;

  function automatic logic [31:0] cneg(input logic [31:0] x, input logic neg);
    return neg ? (32'd0 - x) : x;
  endfunction

  logic        is_signed_in;
  logic        div_zero;
  logic        overflow;
  logic [64:0] tag_in;
  logic        cache_hit;
  logic        fast;
  logic        accept;
  logic [31:0] fast_q;
  logic [31:0] fast_r;
  logic [31:0] fast_result;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign is_signed_in = ~bus.op[0];
  assign div_zero     = (bus.rs2 == 32'd0);
  assign overflow     = is_signed_in && (bus.rs1 == 32'h8000_0000) && (bus.rs2 == 32'hFFFF_FFFF);
  assign tag_in       = {is_signed_in, bus.rs1, bus.rs2};
  assign cache_hit    = cache_valid && (tag_in == cache_tag);
  assign fast         = div_zero | overflow | cache_hit;
  assign accept       = (state == IDLE) && bus.req_valid && !bus.flush;

  // Divide-by-zero and overflow take priority; a hit can only repeat them anyway.
  always_comb begin
    fast_q = cache_q;
    fast_r = cache_r;
    if (div_zero) begin
      fast_q = 32'hFFFF_FFFF;
      fast_r = bus.rs1;
    end else if (overflow) begin
      fast_q = 32'h8000_0000;
      fast_r = 32'd0;
    end
  end

  assign fast_result = bus.op[1] ? fast_r : fast_q;
  assign q_fix       = cneg(cq_r, sq_r);
  assign r_fix       = cneg(cr_r, sr_r);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = fast ? DONE : START;
      START:   state_nx = bus.flush ? DRAIN : WAIT;
      WAIT: begin
        if (bus.core_resp)  state_nx = bus.flush ? IDLE : FIXUP;
        else if (bus.flush) state_nx = DRAIN;
      end
      FIXUP:   state_nx = bus.flush ? IDLE : DONE;
      DONE:    state_nx = IDLE;
      DRAIN:   if (bus.core_resp) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r        <= 2'd0;
      rs1_r       <= 32'd0;
      rs2_r       <= 32'd0;
      sq_r        <= 1'b0;
      sr_r        <= 1'b0;
      cq_r        <= 32'd0;
      cr_r        <= 32'd0;
      result_r    <= 32'd0;
      core_num_r  <= 32'd0;
      core_den_r  <= 32'd0;
      cache_valid <= 1'b0;
      cache_tag   <= 65'd0;
      cache_q     <= 32'd0;
      cache_r     <= 32'd0;
    end else begin
      if (accept) begin
        op_r  <= bus.op;
        rs1_r <= bus.rs1;
        rs2_r <= bus.rs2;
        sq_r  <= is_signed_in & (bus.rs1[31] ^ bus.rs2[31]);
        sr_r  <= is_signed_in & bus.rs1[31];
        if (fast) begin
          result_r <= fast_result;
        end else begin
          core_num_r <= cneg(bus.rs1, is_signed_in & bus.rs1[31]);
          core_den_r <= cneg(bus.rs2, is_signed_in & bus.rs2[31]);
        end
      end
      if ((state == WAIT) && bus.core_resp) begin
        cq_r <= bus.core_quotient;
        cr_r <= bus.core_remainder;
      end
      // A flushed FIXUP must leave both the result and the cache untouched.
      if ((state == FIXUP) && !bus.flush) begin
        result_r    <= op_r[1] ? r_fix : q_fix;
        cache_valid <= 1'b1;
        cache_tag   <= {~op_r[0], rs1_r, rs2_r};
        cache_q     <= q_fix;
        cache_r     <= r_fix;
      end
    end
  end

  assign bus.stall            = bus.req_valid && !bus.flush && (state != DONE);
  assign bus.resp_valid       = (state == DONE);
  assign bus.result           = result_r;
  assign bus.core_start       = (state == START);
  assign bus.core_numerator   = core_num_r;
  assign bus.core_denominator = core_den_r;

endmodule
`default_nettype wire

// File: tb/tb_m_div_unit.sv
`default_nettype none
// ============================================================================
//  tb_m_div_unit
//  Scoreboard bench for m_div_unit with a fixed-latency divider-core model.
//  Revision: 1.0
// ============================================================================
module tb_m_div_unit;

  localparam int LAT = 34;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   start_cnt;
  int   cnt;
  logic [31:0] last_num;
  logic [31:0] last_den;
  logic [31:0] exp_q[$];
  logic        prev_rv;

  m_div_unit_if bus ();

  m_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Unsigned divider core: responds LAT cycles after the start pulse.
  initial begin
    cnt = 0;
    start_cnt = 0;
    last_num = 32'd0;
    last_den = 32'd0;
    bus.core_resp = 1'b0;
    bus.core_quotient = 32'hDEAD_BEEF;
    bus.core_remainder = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      bus.core_resp = 1'b0;
      bus.core_quotient = 32'hDEAD_BEEF;
      bus.core_remainder = 32'hDEAD_BEEF;
      if (!rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.core_resp = 1'b1;
            bus.core_quotient = last_num / last_den;
            bus.core_remainder = last_num % last_den;
          end
        end
        if (bus.core_start) begin
          check_val("start_while_busy", cnt, 0);
          start_cnt++;
          last_num = bus.core_numerator;
          last_den = bus.core_denominator;
          cnt = LAT;
        end
      end
    end
  end

  // Response monitor: every resp_valid pops one expected result.
  initial begin
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.resp_valid) begin
        check_val("resp_back_to_back", prev_rv, 0);
        if (exp_q.size() == 0) check_val("resp_unexpected", bus.resp_valid, 0);
        else check_val("result", bus.result, exp_q.pop_front());
      end
      prev_rv = bus.resp_valid;
    end
  end

  task automatic wait_resp(output bit got);
    int n;
    n = 0;
    while (!bus.resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    got = bus.resp_valid;
    if (!got) check_val("resp_timeout", bus.resp_valid, 1);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit fast);
    int t0;
    int s0;
    bit got;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.op = o;
    bus.rs1 = a;
    bus.rs2 = b;
    exp_q.push_back(exp);
    t0 = cyc;
    s0 = start_cnt;
    @(negedge clk);
    check_val("stall_accept", bus.stall, 1);
    wait_resp(got);
    if (got) begin
      check_val("latency", cyc - t0, fast ? 1 : LAT + 3);
      check_val("core_starts", start_cnt - s0, fast ? 0 : 1);
      check_val("stall_done", bus.stall, 0);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    bit got;
    int s0;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.op = 2'd0;
    bus.rs1 = 32'd0;
    bus.rs2 = 32'd0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_resp_valid", bus.resp_valid, 0);
    check_val("rst_result", bus.result, 0);
    check_val("rst_core_start", bus.core_start, 0);
    check_val("rst_core_num", bus.core_numerator, 0);
    check_val("rst_core_den", bus.core_denominator, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Signed divide through the core, then REM served from the cache.
    issue(2'b00, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 1'b0);
    check_val("core_num_abs", last_num, 32'd20);
    check_val("core_den", last_den, 32'd3);
    issue(2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 1'b1);

    // Divide by zero and signed overflow.
    issue(2'b01, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);
    issue(2'b10, 32'd7, 32'd0, 32'd7, 1'b1);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);

    // Cache hit and miss.
    issue(2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
    issue(2'b11, 32'd100, 32'd7, 32'd2, 1'b1);
    issue(2'b11, 32'd100, 32'd8, 32'd4, 1'b0);

    // Flush while IDLE: nothing is accepted.
    s0 = start_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.flush = 1'b1;
    bus.op = 2'b01;
    bus.rs1 = 32'd1;
    bus.rs2 = 32'd1;
    @(negedge clk);
    check_val("flush_idle_stall", bus.stall, 0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    check_val("flush_idle_starts", start_cnt - s0, 0);

    // Flush in WAIT: drain the core, then a stalled request hits the old entry.
    s0 = start_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.op = 2'b01;
    bus.rs1 = 32'd50;
    bus.rs2 = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    check_val("flush_stall", bus.stall, 0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.op = 2'b11;
    bus.rs1 = 32'd100;
    bus.rs2 = 32'd8;
    exp_q.push_back(32'd4);
    @(negedge clk);
    check_val("drain_stall", bus.stall, 1);
    check_val("drain_no_resp", bus.resp_valid, 0);
    wait_resp(got);
    if (got) check_val("drain_starts", start_cnt - s0, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    issue(2'b01, 32'd9, 32'd2, 32'd4, 1'b0);
    issue(2'b11, 32'd9, 32'd2, 32'd1, 1'b1);

    // Reset in WAIT abandons the operation and clears the cache.
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.op = 2'b01;
    bus.rs1 = 32'd1000;
    bus.rs2 = 32'd10;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_wait_resp_valid", bus.resp_valid, 0);
    check_val("rst_wait_result", bus.result, 0);
    check_val("rst_wait_core_start", bus.core_start, 0);
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    issue(2'b11, 32'd100, 32'd7, 32'd2, 1'b0);

    repeat (5) @(negedge clk);
    check_val("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m_div_unit.md
# m_div_unit

RV32M divide front-end between the execute stage and the iterative unsigned divider core. Accepts DIV/DIVU/REM/REMU requests, handles sign conversion, divide-by-zero and signed overflow, and caches the last result so a DIV/REM pair on the same operands completes in one cycle. It drives a stall to the pipeline and returns a 32-bit result with a one-cycle valid pulse.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  EX holds a divide-class instruction
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1, rs2  in  32  dividend, divisor
- flush  in  1  pipeline kill of the current instruction
- stall  out  1  EX must hold; combinational
- resp_valid  out  1  one-cycle pulse; result valid
- result  out  32  quotient or remainder per op
- core_start  out  1  start pulse to the unsigned divider core
- core_numerator, core_denominator  out  32  core operands; held stable from START until core_resp
- core_quotient, core_remainder  in  32  core results; valid only in the cycle core_resp=1
- core_resp  in  1  core completion pulse

## Operation
- **States:** IDLE, START, WAIT, FIXUP, DONE, DRAIN.
- **Acceptance:** a request is accepted only in IDLE, with req_valid=1 and flush=0. On acceptance, latch op, rs1 and rs2.
  - is_signed = !op[0].
  - Signs: sq = signed & (rs1[31]^rs2[31]); sr = signed & rs1[31].
- **Fast path** (IDLE -> DONE; core untouched):
  - rs2==0: quotient = 0xFFFFFFFF, remainder = rs1.
  - Signed, rs1==0x80000000 and rs2==0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Cache hit: cache_valid, with {is_signed, rs1, rs2} equal to the cached tag. Return the cached quotient or remainder.
- **Normal path** (IDLE -> START):
  - core_numerator = signed ? |rs1| : rs1; core_denominator likewise from rs2.
  - Two's-complement magnitude; |0x80000000| = 0x80000000 unsigned.
- **START:** core_start=1 for exactly this cycle, then go to WAIT.
- **WAIT:** on core_resp, capture core_quotient and core_remainder, then go to FIXUP.
- **FIXUP:**
  - q = sq ? -cq : cq; r = sr ? -cr : cr.
  - Register result = op[1] ? r : q.
  - Write the cache: tag {is_signed, rs1, rs2}, q, r; set cache_valid.
  - Go to DONE.
- **DONE:** resp_valid=1, then go to IDLE. req_valid in DONE is the completing instruction and is ignored.
- **Stall:** stall = req_valid & !flush & (state != DONE). This includes the IDLE acceptance cycle and DRAIN.
- **Flush:**
  - In IDLE: no acceptance.
  - In START or WAIT: go to DRAIN. If core_resp is in the same WAIT cycle, go to IDLE instead.
  - In FIXUP: go to IDLE; no response, no cache write.
  - In DONE: no effect; resp_valid still pulses.
- **DRAIN:** wait for core_resp, discard it, go to IDLE. No core_start and no acceptance until then.
- **Cache:** the cache is written only from FIXUP. Fast-path results are not cached.
- **Reset:** rst is shared with the core.
  - Reset values: state=IDLE, resp_valid=0, result=0, core_start=0, core operands=0, cache_valid=0.
  - Reset mid-operation abandons everything, with no response.

## Timing
- Accept at cycle T.
- Fast path: resp_valid at T+1.
- Normal path:
  - core_start at T+1.
  - If core_resp arrives at cycle C, resp_valid is at C+2.
  - With a core latency of 34 cycles from start to resp, resp_valid is at T+37.
- resp_valid is never high on two consecutive cycles.
- core_start is never reasserted before the prior core_resp.
- The earliest next acceptance is the cycle after DONE.
- result holds its value until the next FIXUP or fast-path load.

## Test plan
- **Signed divide, then cache hit:** DIV rs1=0xFFFFFFEC (-20), rs2=3 -> result 0xFFFFFFFA at C+2, core_numerator=20. Then REM with the same operands -> 0xFFFFFFFE at T+1, with no core_start.
- **Divide by zero:** DIVU 0/0 -> 0xFFFFFFFF at T+1. REM 7/0 -> 7. core_start stays 0 throughout.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0. Both at T+1.
- **Cache hit and miss:** DIVU 100/7 -> 14, with one core_start pulse. REMU 100/7 -> 2 at T+1 (hit). REMU 100/8 -> 4 via the core (miss on rs2).
- **Flush in WAIT:** goes to DRAIN, with no resp_valid. stall=1 for a new request until core_resp. The next DIVU 9/2 -> 4 normally, and the cache still holds the prior entry.
- **Reset in WAIT:** rst low -> resp_valid, result and core_start go to 0 immediately. After release, REMU 100/7 misses the cache and goes via the core.
